// File: rtl/pattern_detector_n.sv
// Serial pattern detector: shifts in qualified bits, flags a WIDTH-bit match one
// clock later, and keeps a saturating count of matches.
module pattern_detector_n #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    input  logic             valid,
    input  logic             clear,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic [WIDTH-1:0] history
);

    localparam int               FILL_W   = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [WIDTH-1:0]  hist;
    logic [WIDTH-1:0]  hist_next;
    logic [FILL_W-1:0] fill;
    logic              match;

    // The fill guard keeps a reset-valued hist from matching an all-zero pattern.
    always_comb begin
        hist_next = {hist[WIDTH-2:0], in};
        match     = valid && (hist_next == PATTERN) && (fill >= FILL_PRE);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            out         <= 1'b0;
        end else begin
            out <= match;
            if (valid) begin
                hist <= hist_next;
                if (match && !OVERLAP)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + FILL_W'(1);
            end
            if (match && (match_count != CNT_MAX))
                match_count <= match_count + CNT_W'(1);
        end
    end

    assign history = hist;

endmodule

// File: tb/tb_pattern_detector_n.sv
// Scoreboard bench for pattern_detector_n: five parameter variants share one
// stimulus bus; each step names the variant whose response it expects.
module tb_pattern_detector_n;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in    = 1'b0;
    logic valid = 1'b0;
    logic clear = 1'b0;

    logic       out_a, out_b, out_c, out_d, out_e;
    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic [1:0] cnt_e;
    logic [3:0] hist_a, hist_b, hist_c, hist_d, hist_e;

    always #5 clock = ~clock;

    // a: 1011 overlapping, b: 1011 non-overlapping, c/d: 0000 with/without
    // overlap, e: 1011 with a 2-bit counter.
    pattern_detector_n #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .in(in), .valid(valid), .clear(clear),
        .out(out_a), .match_count(cnt_a), .history(hist_a));
    pattern_detector_n #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clock(clock), .reset(reset), .in(in), .valid(valid), .clear(clear),
        .out(out_b), .match_count(cnt_b), .history(hist_b));
    pattern_detector_n #(.WIDTH(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) dut_c (
        .clock(clock), .reset(reset), .in(in), .valid(valid), .clear(clear),
        .out(out_c), .match_count(cnt_c), .history(hist_c));
    pattern_detector_n #(.WIDTH(4), .PATTERN(4'b0000), .OVERLAP(1'b0), .CNT_W(8)) dut_d (
        .clock(clock), .reset(reset), .in(in), .valid(valid), .clear(clear),
        .out(out_d), .match_count(cnt_d), .history(hist_d));
    pattern_detector_n #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_e (
        .clock(clock), .reset(reset), .in(in), .valid(valid), .clear(clear),
        .out(out_e), .match_count(cnt_e), .history(hist_e));

    typedef struct {
        int         sel;
        logic       exp_out;
        logic [7:0] exp_cnt;
        logic [3:0] exp_hist;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got out/cnt/hist=%b/%h/%b, required %b/%h/%b",
                     name, act[12], act[11:4], act[3:0], req[12], req[11:4], req[3:0]);
    endtask

    // Apply one edge's inputs and queue the response expected after that edge.
    task automatic step(input bit r, input bit c, input bit v, input bit i, input int s,
                        input bit eo, input logic [7:0] ec, input logic [3:0] eh,
                        input string nm);
        exp_t e;
        @(negedge clock);
        reset = r; clear = c; valid = v; in = i;
        e.sel = s; e.exp_out = eo; e.exp_cnt = ec; e.exp_hist = eh; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic feed(input bit i, input int s, input bit eo, input logic [7:0] ec,
                        input logic [3:0] eh, input string nm);
        step(1'b0, 1'b0, 1'b1, i, s, eo, ec, eh, nm);
    endtask

    // Monitor: the detector presents a response every clock, so each edge that
    // has a queued expectation is compared shortly after it.
    initial begin
        exp_t       e;
        logic [12:0] act;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.sel)
                    0:       act = {out_a, cnt_a, hist_a};
                    1:       act = {out_b, cnt_b, hist_b};
                    2:       act = {out_c, cnt_c, hist_c};
                    3:       act = {out_d, cnt_d, hist_d};
                    default: act = {out_e, 6'd0, cnt_e, hist_e};
                endcase
                check(e.name, act, {e.exp_out, e.exp_cnt, e.exp_hist});
            end
        end
    end

    initial begin
        // Reset held two cycles with in toggling, then one clean match.
        step(1, 0, 1, 1, 0, 0, 0, 4'b0000, "rst_hold1");
        step(1, 0, 1, 0, 0, 0, 0, 4'b0000, "rst_hold2");
        feed(1, 0, 0, 0, 4'b0001, "rst_b1");
        feed(0, 0, 0, 0, 4'b0010, "rst_b2");
        feed(1, 0, 0, 0, 4'b0101, "rst_b3");
        feed(1, 0, 1, 1, 4'b1011, "rst_match");
        step(0, 0, 0, 0, 0, 0, 1, 4'b1011, "rst_pulse_end");

        // Overlapping stream 1011011.
        step(1, 0, 0, 0, 0, 0, 0, 4'b0000, "ov1_reset");
        feed(1, 0, 0, 0, 4'b0001, "ov1_b1");
        feed(0, 0, 0, 0, 4'b0010, "ov1_b2");
        feed(1, 0, 0, 0, 4'b0101, "ov1_b3");
        feed(1, 0, 1, 1, 4'b1011, "ov1_b4");
        feed(0, 0, 0, 1, 4'b0110, "ov1_b5");
        feed(1, 0, 0, 1, 4'b1101, "ov1_b6");
        feed(1, 0, 1, 2, 4'b1011, "ov1_b7");

        // Same stream without overlap: the second 1011 reuses bits, so no pulse.
        step(1, 0, 0, 0, 1, 0, 0, 4'b0000, "ov0_reset");
        feed(1, 1, 0, 0, 4'b0001, "ov0_b1");
        feed(0, 1, 0, 0, 4'b0010, "ov0_b2");
        feed(1, 1, 0, 0, 4'b0101, "ov0_b3");
        feed(1, 1, 1, 1, 4'b1011, "ov0_b4");
        feed(0, 1, 0, 1, 4'b0110, "ov0_b5");
        feed(1, 1, 0, 1, 4'b1101, "ov0_b6");
        feed(1, 1, 0, 1, 4'b1011, "ov0_b7");

        // All-zero pattern: the fill guard blocks matches on the reset history.
        step(1, 0, 0, 0, 2, 0, 0, 4'b0000, "z1_reset");
        feed(0, 2, 0, 0, 4'b0000, "z1_b1");
        feed(0, 2, 0, 0, 4'b0000, "z1_b2");
        feed(0, 2, 0, 0, 4'b0000, "z1_b3");
        feed(0, 2, 1, 1, 4'b0000, "z1_b4");
        feed(0, 2, 1, 2, 4'b0000, "z1_b5");
        step(1, 0, 0, 0, 3, 0, 0, 4'b0000, "z0_reset");
        feed(0, 3, 0, 0, 4'b0000, "z0_b1");
        feed(0, 3, 0, 0, 4'b0000, "z0_b2");
        feed(0, 3, 0, 0, 4'b0000, "z0_b3");
        feed(0, 3, 1, 1, 4'b0000, "z0_b4");
        feed(0, 3, 0, 1, 4'b0000, "z0_b5");

        // Valid gaps with in=1 must not shift.
        step(1, 0, 0, 0, 0, 0, 0, 4'b0000, "gap_reset");
        feed(1, 0, 0, 0, 4'b0001, "gap_b1");
        feed(0, 0, 0, 0, 4'b0010, "gap_b2");
        step(0, 0, 0, 1, 0, 0, 0, 4'b0010, "gap_idle1");
        step(0, 0, 0, 1, 0, 0, 0, 4'b0010, "gap_idle2");
        step(0, 0, 0, 1, 0, 0, 0, 4'b0010, "gap_idle3");
        feed(1, 0, 0, 0, 4'b0101, "gap_b3");
        feed(1, 0, 1, 1, 4'b1011, "gap_b4");

        // Counter saturation at 3 with CNT_W=2, then clear beats valid.
        step(1, 0, 0, 0, 4, 0, 0, 4'b0000, "sat_reset");
        feed(1, 4, 0, 0, 4'b0001, "sat_b1");
        feed(0, 4, 0, 0, 4'b0010, "sat_b2");
        feed(1, 4, 0, 0, 4'b0101, "sat_b3");
        feed(1, 4, 1, 1, 4'b1011, "sat_m1");
        for (int k = 2; k <= 5; k++) begin
            feed(0, 4, 0, 8'((k - 1 > 3) ? 3 : k - 1), 4'b0110, $sformatf("sat_m%0d_b0", k));
            feed(1, 4, 0, 8'((k - 1 > 3) ? 3 : k - 1), 4'b1101, $sformatf("sat_m%0d_b1", k));
            feed(1, 4, 1, 8'((k > 3) ? 3 : k), 4'b1011, $sformatf("sat_m%0d", k));
        end
        step(0, 1, 1, 1, 4, 0, 0, 4'b0000, "clear");

        // Reset mid-stream discards the partial 101.
        step(1, 0, 0, 0, 0, 0, 0, 4'b0000, "mid_reset0");
        feed(1, 0, 0, 0, 4'b0001, "mid_b1");
        feed(0, 0, 0, 0, 4'b0010, "mid_b2");
        feed(1, 0, 0, 0, 4'b0101, "mid_b3");
        step(1, 0, 1, 1, 0, 0, 0, 4'b0000, "mid_reset");
        feed(1, 0, 0, 0, 4'b0001, "mid_after1");
        feed(0, 0, 0, 0, 4'b0010, "mid_after2");
        feed(1, 0, 0, 0, 4'b0101, "mid_after3");
        feed(1, 0, 1, 1, 4'b1011, "mid_match");
        step(1, 1, 1, 1, 0, 0, 0, 4'b0000, "reset_over_clear");

        @(negedge clock);
        valid = 1'b0; reset = 1'b0; clear = 1'b0;
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_detector_n.md
PATTERN_DETECTOR_N -- requirements
Module: pattern_detector_n

Interface
REQ-001 SHALL have parameter WIDTH, 4, pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter PATTERN, 4'b1011, WIDTH-bit target sequence; MSB is the oldest bit received.
REQ-003 SHALL have parameter OVERLAP, 1, 1 = overlapping matches allowed, 0 = the bits of a match are not reused.
REQ-004 SHALL have parameter CNT_W, 8, width of the match counter.
REQ-005 SHALL have port clock  in  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port in  in  1  serial data bit.
REQ-008 SHALL have port valid  in  1  qualifies in; bits are consumed only when valid=1.
REQ-009 SHALL have port clear  in  1  synchronous soft clear of history, fill count and match count.
REQ-010 SHALL have port out  out  1  registered match pulse.
REQ-011 SHALL have port match_count  out  CNT_W  number of matches since reset or clear, saturating.
REQ-012 SHALL have port history  out  WIDTH  last WIDTH accepted bits, newest in the LSB.

Function
REQ-013 SHALL keep a WIDTH-bit shift register hist; on an edge with valid=1, hist <= {hist[WIDTH-2:0], in}.
REQ-014 SHALL keep fill, a counter of width clog2(WIDTH+1), incremented on each accepted bit and saturating at WIDTH.
REQ-015 SHALL define match = valid & (next hist == PATTERN) & (fill+1 >= WIDTH), evaluated on the accepting edge.
REQ-016 SHALL register out <= match, so out is 1 for exactly the cycle after the edge that accepts the last pattern bit; latency is 1 clock.
REQ-017 SHALL drive out=0 in the cycle after any edge with valid=0; hist and fill SHALL hold on such edges.
REQ-018 SHALL, when OVERLAP=1, leave fill saturated at WIDTH after a match, so consecutive matches may share bits.
REQ-019 SHALL, when OVERLAP=0, load fill with 0 on a match edge, so the next match needs WIDTH fresh accepted bits; hist still shifts normally.
REQ-020 SHALL increment match_count by 1 on each match edge and hold it at 2^CNT_W-1 once that value is reached (no wrap).
REQ-021 SHALL, on an edge with clear=1, set hist=0, fill=0, match_count=0 and out=0, ignoring in and valid on that edge.
REQ-022 SHALL make no match possible before WIDTH bits have been accepted, including when PATTERN equals the reset value of hist (for example all zeros).
REQ-023 SHALL drive history = hist at all times.
REQ-024 SHALL produce no X on any output after the first reset edge.

Reset
REQ-025 SHALL, on an edge with reset=1, set hist=0, fill=0, match_count=0 and out=0.
REQ-026 SHALL give reset priority over clear, and clear priority over valid.
REQ-027 SHALL discard any partial sequence on reset mid-stream; detection restarts from an empty fill.

Verification
(Defaults unless stated: WIDTH=4, PATTERN=1011, valid=1.)
REQ-028 SHALL check reset: hold reset for 2 cycles with in toggling -> out=0, match_count=0, history=0000; then feed 1,0,1,1 -> out=1 for exactly one cycle after the 4th edge, match_count=1.
REQ-029 SHALL check overlap: with OVERLAP=1, feed 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7, match_count=2; with OVERLAP=0, the same stream -> a single pulse after bit 4, match_count=1.
REQ-030 SHALL check the fill guard: with PATTERN=0000, feed 0,0,0 -> out stays 0; the 4th 0 -> out=1; a 5th 0 -> out=1 again when OVERLAP=1, and out=0 when OVERLAP=0.
REQ-031 SHALL check valid gaps: feed 1,0, then valid=0 for 3 cycles with in=1, then 1,1 -> no pulse during the gap, one pulse after the last 1, history=1011.
REQ-032 SHALL check saturation and clear: with CNT_W=2, produce 5 matches -> match_count=3; then clear=1 for one cycle -> match_count=0, history=0000, out=0.
REQ-033 SHALL check reset mid-stream: feed 1,0,1, pulse reset, then feed 1 -> no pulse; then feed 0,1,1 -> a pulse after the final 1.
